irq_unit: RTL and testbench
===========================

IRQ_UNIT -- requirements
Module: irq_unit

Interface
REQ-001 Parameter NUM_IRQ, default 32, number of request channels; legal range 2..32.
REQ-002 Parameter NEST_DEPTH, default 4, maximum nested interrupt levels; legal range 1..8.
REQ-003 Parameter VEC_BASE, default 32'h1C00_8000, base address of the vector table.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 res  in  1  reset, asynchronous, active-low.
REQ-006 irq_in  in  NUM_IRQ  level request lines; bit i is interrupt id i.
REQ-007 irq_mask  in  NUM_IRQ  per-channel enable; 1 = enabled.
REQ-008 glob_en  in  1  global interrupt enable.
REQ-009 take_rdy  in  1  core is at an instruction boundary and can accept a trap.
REQ-010 pc_in  in  32  return address to save on trap entry.
REQ-011 mret  in  1  one-cycle pulse; handler return.
REQ-012 irq_take  out  1  one-cycle pulse; core loads vec_adr into the PC.
REQ-013 vec_adr  out  32  handler address; valid while irq_take = 1.
REQ-014 ret_adr  out  32  top-of-stack return address.
REQ-015 irq_ack  out  1  one-cycle acknowledge pulse.
REQ-016 irq_ack_id  out  5  id being acknowledged.
REQ-017 in_handler  out  1  nest_lvl != 0.
REQ-018 nest_lvl  out  4  current nesting depth.
REQ-019 err  out  1  sticky error flag.

Function
REQ-020 pending = irq_in & irq_mask; winner = lowest-index set bit of pending (id 0 has the highest priority).
REQ-021 Candidate is valid when all of the following hold:
- glob_en = 1
- pending != 0
- nest_lvl < NEST_DEPTH
- nest_lvl = 0, or winner < the id on top of the stack (strict preemption only).
REQ-022 The FSM has states IDLE, TAKE and ACK; reset state is IDLE.
REQ-023 IDLE -> TAKE when take_rdy = 1, the candidate is valid and mret = 0. On that edge:
- push {winner, pc_in} onto the stack
- nest_lvl += 1
REQ-024 In TAKE: irq_take = 1 and vec_adr = VEC_BASE + (id << 2), modulo 2^32; the FSM goes to ACK unconditionally.
REQ-025 In ACK: irq_ack = 1 and irq_ack_id = the pushed id; the FSM goes to IDLE unconditionally.
REQ-026 Latency: candidate sampled at edge N gives irq_take high in cycle N+1 and irq_ack high in cycle N+2.
REQ-027 Once in TAKE, the trap is committed; deassertion of irq_in or irq_mask does not abort it.
REQ-028 mret in IDLE with nest_lvl > 0: pop the stack and decrement nest_lvl on the same edge. ret_adr is valid in the cycle mret is asserted.
REQ-029 mret in IDLE with nest_lvl = 0: stack unchanged; err is set.
REQ-030 mret in TAKE or ACK is ignored, and err is set.
REQ-031 mret and a valid candidate in the same IDLE cycle: mret wins; the candidate is re-evaluated on the next cycle.
REQ-032 When nest_lvl = NEST_DEPTH, no new take occurs; err is not set.
REQ-033 When nest_lvl = 0, ret_adr = 32'h0; vec_adr = 32'h0 outside TAKE; irq_ack_id holds its last value.
REQ-034 err stays set until reset.

Reset
REQ-035 When res = 0, asynchronously:
- FSM to IDLE
- nest_lvl = 0
- stack cleared
- irq_take, irq_ack and err = 0
- irq_ack_id = 5'b00000
- vec_adr and ret_adr = 0
REQ-036 Reset mid-TAKE or mid-ACK aborts the trap with no further irq_take or irq_ack pulse; operation resumes from IDLE on the first edge after res returns to 1.

Verification
REQ-037 The bench shall cover the following directed scenarios:
- Basic take: irq_in[3]=1, mask all 1, glob_en=1, take_rdy=1, pc_in=32'h100 -> next cycle irq_take=1, vec_adr=32'h1C00_800C; following cycle irq_ack=1, irq_ack_id=3; nest_lvl=1, ret_adr=32'h100.
- Priority: irq_in bits 5 and 2 set together -> id 2 taken, vec_adr=32'h1C00_8008.
- Nesting: handler for id 5 active (pc_in=32'h200 at entry); irq_in[1] with pc_in=32'h300 -> nest_lvl=2, ret_adr=32'h300. irq_in[7] is never taken. mret -> ret_adr=32'h200, nest_lvl=1.
- Depth limit: NEST_DEPTH=2 with two levels active; a higher-priority irq is not taken until after mret; err=0.
- Boundary: mret with nest_lvl=0 -> err=1 and stays set. mret together with a valid candidate -> pop first, take one cycle later.
- Reset mid-TAKE: res=0 -> irq_take drops immediately, nest_lvl=0, and no irq_ack is issued.

Source files
------------

// File: rtl/irq_unit.sv
// Nested vectored interrupt unit: fixed-priority arbitration,
// strict preemption and a return-address stack.
module irq_unit #(
  parameter int          NUM_IRQ    = 32,
  parameter int          NEST_DEPTH = 4,
  parameter logic [31:0] VEC_BASE   = 32'h1C00_8000
) (
  input  logic               clk,
  input  logic               res,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               glob_en,
  input  logic               take_rdy,
  input  logic [31:0]        pc_in,
  input  logic               mret,
  output logic               irq_take,
  output logic [31:0]        vec_adr,
  output logic [31:0]        ret_adr,
  output logic               irq_ack,
  output logic [4:0]         irq_ack_id,
  output logic               in_handler,
  output logic [3:0]         nest_lvl,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE,
    TAKE,
    ACK
  } state_t;

  state_t state, state_nxt;

  logic [4:0]  stk_id [NEST_DEPTH];
  logic [31:0] stk_pc [NEST_DEPTH];

  logic [NUM_IRQ-1:0] pending;
  logic [4:0]  win;
  logic [4:0]  top_id;
  logic [31:0] top_pc;
  logic [4:0]  ack_id_q;
  logic [3:0]  lvl_q;
  logic        cand;
  logic        push;
  logic        pop;
  logic        err_set;

  assign pending = irq_in & irq_mask;

  // Lowest index wins: scan downwards so the last hit is the smallest id.
  always_comb begin
    win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) win = 5'(i);
    end
  end

  always_comb begin
    top_id = '0;
    top_pc = '0;
    for (int i = 0; i < NEST_DEPTH; i++) begin
      if (lvl_q == 4'(i + 1)) begin
        top_id = stk_id[i];
        top_pc = stk_pc[i];
      end
    end
  end

  assign cand = glob_en && (|pending)
             && (lvl_q < 4'(NEST_DEPTH))
             && ((lvl_q == 4'd0) || (win < top_id));

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    pop       = 1'b0;
    err_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (mret) begin
          if (lvl_q != 4'd0) pop = 1'b1;
          else err_set = 1'b1;
        end else if (take_rdy && cand) begin
          push      = 1'b1;
          state_nxt = TAKE;
        end
      end
      TAKE: begin
        err_set   = mret;
        state_nxt = ACK;
      end
      ACK: begin
        err_set   = mret;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state    <= IDLE;
      lvl_q    <= '0;
      err      <= 1'b0;
      ack_id_q <= '0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        stk_id[i] <= '0;
        stk_pc[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (err_set) err <= 1'b1;
      if (push) lvl_q <= lvl_q + 4'd1;
      else if (pop) lvl_q <= lvl_q - 4'd1;
      // The freshly pushed entry is on top for the whole TAKE cycle.
      if (state == TAKE) ack_id_q <= top_id;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        if (push && (lvl_q == 4'(i))) begin
          stk_id[i] <= win;
          stk_pc[i] <= pc_in;
        end
      end
    end
  end

  assign irq_take   = (state == TAKE);
  assign irq_ack    = (state == ACK);
  assign vec_adr    = irq_take ? VEC_BASE + {25'd0, top_id, 2'b00} : 32'h0;
  assign ret_adr    = top_pc;
  assign irq_ack_id = ack_id_q;
  assign in_handler = (lvl_q != 4'd0);
  assign nest_lvl   = lvl_q;

endmodule

// File: tb/tb_irq_unit.sv
// Scoreboard bench for irq_unit: directed scenarios then random
// traffic against a stack-based reference model.
module tb_irq_unit;

  localparam int          ND  = 2;
  localparam logic [31:0] VB  = 32'h1C00_8000;
  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        res;
  logic [31:0] irq_in, irq_mask, pc_in;
  logic        glob_en, take_rdy, mret;
  logic        irq_take, irq_ack, in_handler, err;
  logic [31:0] vec_adr, ret_adr;
  logic [4:0]  irq_ack_id;
  logic [3:0]  nest_lvl;

  irq_unit #(.NUM_IRQ(32), .NEST_DEPTH(ND), .VEC_BASE(VB)) dut (
    .clk(clk), .res(res), .irq_in(irq_in), .irq_mask(irq_mask),
    .glob_en(glob_en), .take_rdy(take_rdy), .pc_in(pc_in), .mret(mret),
    .irq_take(irq_take), .vec_adr(vec_adr), .ret_adr(ret_adr),
    .irq_ack(irq_ack), .irq_ack_id(irq_ack_id), .in_handler(in_handler),
    .nest_lvl(nest_lvl), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  id;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_stk[$];
  int          m_ph;
  bit          m_err;
  logic [4:0]  last_id;
  logic [31:0] take_q[$];
  logic [4:0]  ack_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  bit          mon_on = 0;
  logic [31:0] exp_ret;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
  endtask

  // Reference: trap entry takes two cycles (take, ack) before the next decision.
  task automatic model_edge();
    logic [31:0] p;
    int w;
    p = irq_in & irq_mask;
    w = -1;
    for (int i = 31; i >= 0; i--) if (p[i]) w = i;
    case (m_ph)
      0: begin
        if (mret) begin
          if (m_stk.size() > 0) void'(m_stk.pop_back());
          else m_err = 1;
        end else if (take_rdy && glob_en && w >= 0 && m_stk.size() < ND
                     && (m_stk.size() == 0 || w < int'(m_stk[$].id))) begin
          m_stk.push_back('{id: 5'(w), pc: pc_in});
          m_ph = 1;
          take_q.push_back(VB + 32'(w) * 4);
          ack_q.push_back(5'(w));
        end
      end
      1: begin
        if (mret) m_err = 1;
        m_ph = 2;
      end
      default: begin
        if (mret) m_err = 1;
        m_ph = 0;
      end
    endcase
  endtask

  task automatic step(logic [31:0] irq, logic [31:0] msk, logic ge,
                      logic tr, logic [31:0] pc, logic mr);
    irq_in = irq; irq_mask = msk; glob_en = ge;
    take_rdy = tr; pc_in = pc; mret = mr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) step(32'h0, ALL, 1'b1, 1'b1, 32'h0, 1'b0);
  endtask

  task automatic do_reset(int cyc);
    res = 1'b0;
    #1;
    m_stk.delete(); m_ph = 0; m_err = 0; last_id = '0;
    take_q.delete(); ack_q.delete();
    chk("rst_take", {31'd0, irq_take}, 32'd0);
    chk("rst_ack", {31'd0, irq_ack}, 32'd0);
    chk("rst_lvl", {28'd0, nest_lvl}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ret", ret_adr, 32'd0);
    chk("rst_ack_id", {27'd0, irq_ack_id}, 32'd0);
    repeat (cyc) @(posedge clk);
    #1;
    res = 1'b1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a take or an ack.
  initial forever begin
    @(negedge clk);
    if (mon_on && res) begin
      chk("irq_take", {31'd0, irq_take}, {31'd0, m_ph == 1});
      if (irq_take) begin
        if (take_q.size() == 0) begin
          n_chk++;
          $display("FAIL take_unexpected actual=1 required=0 t=%0t", $time);
        end else chk("vec_adr", vec_adr, take_q.pop_front());
      end else chk("vec_idle", vec_adr, 32'h0);
      chk("irq_ack", {31'd0, irq_ack}, {31'd0, m_ph == 2});
      if (irq_ack) begin
        if (ack_q.size() == 0) begin
          n_chk++;
          $display("FAIL ack_unexpected actual=1 required=0 t=%0t", $time);
        end else begin
          last_id = ack_q.pop_front();
          chk("irq_ack_id", {27'd0, irq_ack_id}, {27'd0, last_id});
        end
      end else chk("ack_id_hold", {27'd0, irq_ack_id}, {27'd0, last_id});
      exp_ret = 32'h0;
      if (m_stk.size() > 0) exp_ret = m_stk[$].pc;
      chk("nest_lvl", {28'd0, nest_lvl}, m_stk.size());
      chk("in_handler", {31'd0, in_handler}, {31'd0, m_stk.size() != 0});
      chk("ret_adr", ret_adr, exp_ret);
      chk("err", {31'd0, err}, {31'd0, m_err});
    end
  end

  initial begin
    res = 1'b0;
    irq_in = '0; irq_mask = '0; glob_en = 0; take_rdy = 0;
    pc_in = '0; mret = 0;
    m_ph = 0; m_err = 0; last_id = '0;
    @(posedge clk);
    #1;
    do_reset(2);
    mon_on = 1;

    // basic take
    step(32'h8, ALL, 1, 1, 32'h100, 0);
    chk("basic_take", {31'd0, irq_take}, 32'd1);
    chk("basic_vec", vec_adr, 32'h1C00_800C);
    idle(1);
    chk("basic_ack", {31'd0, irq_ack}, 32'd1);
    chk("basic_ack_id", {27'd0, irq_ack_id}, 32'd3);
    idle(1);
    chk("basic_lvl", {28'd0, nest_lvl}, 32'd1);
    chk("basic_ret", ret_adr, 32'h100);
    step(32'h0, ALL, 1, 1, 32'h0, 1);
    chk("basic_pop", {28'd0, nest_lvl}, 32'd0);

    // priority
    step(32'h24, ALL, 1, 1, 32'h40, 0);
    chk("prio_vec", vec_adr, 32'h1C00_8008);
    idle(2);
    step(32'h0, ALL, 1, 1, 32'h0, 1);

    // nesting and strict preemption
    step(32'h20, ALL, 1, 1, 32'h200, 0);
    idle(2);
    step(32'h82, ALL, 1, 1, 32'h300, 0);
    chk("nest_vec", vec_adr, 32'h1C00_8004);
    repeat (5) step(32'h80, ALL, 1, 1, 32'h0, 0);
    chk("nest_lvl2", {28'd0, nest_lvl}, 32'd2);
    chk("nest_ret300", ret_adr, 32'h300);
    step(32'h80, ALL, 1, 1, 32'h0, 1);
    chk("nest_ret200", ret_adr, 32'h200);
    chk("nest_lvl1", {28'd0, nest_lvl}, 32'd1);
    repeat (4) step(32'h80, ALL, 1, 1, 32'h0, 0);
    chk("no_preempt7", {28'd0, nest_lvl}, 32'd1);
    step(32'h0, ALL, 1, 1, 32'h0, 1);

    // depth limit
    step(32'h20, ALL, 1, 1, 32'h500, 0);
    idle(2);
    step(32'h8, ALL, 1, 1, 32'h600, 0);
    idle(2);
    repeat (4) step(32'h1, ALL, 1, 1, 32'h700, 0);
    chk("depth_lvl", {28'd0, nest_lvl}, 32'd2);
    chk("depth_err", {31'd0, err}, 32'd0);
    step(32'h1, ALL, 1, 1, 32'h700, 1);
    chk("depth_pop_lvl", {28'd0, nest_lvl}, 32'd1);
    chk("depth_pop_notake", {31'd0, irq_take}, 32'd0);
    step(32'h1, ALL, 1, 1, 32'h700, 0);
    chk("depth_take", {31'd0, irq_take}, 32'd1);
    chk("depth_vec", vec_adr, 32'h1C00_8000);
    idle(2);
    step(32'h0, ALL, 1, 1, 32'h0, 1);
    step(32'h0, ALL, 1, 1, 32'h0, 1);

    // mret with a valid candidate: pop first, take next cycle
    step(32'h20, ALL, 1, 1, 32'h900, 0);
    idle(2);
    step(32'h4, ALL, 1, 1, 32'hA00, 1);
    chk("mret_cand_lvl", {28'd0, nest_lvl}, 32'd0);
    chk("mret_cand_notake", {31'd0, irq_take}, 32'd0);
    step(32'h4, ALL, 1, 1, 32'hA00, 0);
    chk("mret_cand_take", {31'd0, irq_take}, 32'd1);
    chk("mret_cand_vec", vec_adr, 32'h1C00_8008);
    idle(2);
    step(32'h0, ALL, 1, 1, 32'h0, 1);

    // reset mid-TAKE
    step(32'h10, ALL, 1, 1, 32'hB00, 0);
    chk("midtake_take", {31'd0, irq_take}, 32'd1);
    do_reset(2);
    idle(4);

    // mret with empty stack sets sticky err
    step(32'h0, ALL, 1, 1, 32'h0, 1);
    chk("err_set", {31'd0, err}, 32'd1);
    idle(3);
    chk("err_sticky", {31'd0, err}, 32'd1);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] irq;
      irq = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31))
                                        : ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 399) == 0) do_reset($urandom_range(1, 2));
      else step(irq, $urandom | $urandom, $urandom_range(0, 7) != 0,
                $urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC,
                $urandom_range(0, 9) == 0);
    end

    idle(3);
    chk("take_q_drained", take_q.size(), 32'd0);
    chk("ack_q_drained", ack_q.size(), 32'd0);
    mon_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
